riscv_core_pipe: RTL

Parametrised successor to the single-cycle RV32I core: a 3-stage in-order pipeline (IF, EX, MW) with valid/ready wait-state handshakes on both memory ports. It supports the full RV32I conditional-branch set, LUI/AUIPC, JAL/JALR with link, and LW/SW. It also provides operand forwarding (optional), precise halt on illegal/ECALL/EBREAK/misaligned access, and a retired-instruction counter. It sits at the top of the CPU subsystem and replaces the single-cycle core.

---
 rtl/riscv_pkg.sv | 71 +++++++
 rtl/riscv_hazard_unit.sv | 35 +++
 rtl/riscv_core_pipe.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the 3-stage RV32I pipeline: opcodes, branch funct3 codes,
// ALU operation set, the EX/MW pipeline register and the ALU helpers.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // result carries the ALU value, the link address, or the data address for memory ops
    typedef struct packed {
        logic        valid;
        logic        mem;
        logic        store;
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] sdata;
    } exmw_t;

    function automatic alu_op_e alu_control(input logic [2:0] f3, input logic alt, input logic is_reg);
        alu_op_e op;
        case (f3)
            3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] y;
        case (op)
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {31'b0, a < b};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $signed(a) >>> b[4:0];
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = a + b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/riscv_hazard_unit.sv
// Hazard logic between EX and MW: memory wait stall, RAW stall or bypass selects,
// and the IF/EX flush for redirects and halts.
module riscv_hazard_unit
    import riscv_pkg::*;
#(
    parameter bit FORWARDING = 1'b1
) (
    input  exmw_t      mw,
    input  logic       dmem_ready,
    input  logic       ex_valid,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       ex_redirect,
    input  logic       ex_halt,
    output logic       mem_wait,
    output logic       stall,
    output logic       fwd_a,
    output logic       fwd_b,
    output logic       flush
);

    logic mw_writes;
    logic hit_a;
    logic hit_b;

    assign mw_writes = mw.valid && mw.wb && (mw.rd != 5'd0);
    assign hit_a     = mw_writes && (rs1 == mw.rd);
    assign hit_b     = mw_writes && (rs2 == mw.rd);
    assign mem_wait  = mw.valid && mw.mem && !dmem_ready;
    assign stall     = mem_wait || (!FORWARDING && ex_valid && (hit_a || hit_b));
    assign fwd_a     = FORWARDING && hit_a;
    assign fwd_b     = FORWARDING && hit_b;
    assign flush     = !stall && (ex_redirect || ex_halt);

endmodule

// File: rtl/riscv_core_pipe.sv
// 3-stage (IF, EX, MW) in-order RV32I/RV32E core with handshaked memory ports,
// optional MW-to-EX bypass, precise halt and a retired-instruction counter.
module riscv_core_pipe
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned NUM_REGS   = 32,
    parameter bit          FORWARDING = 1'b1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_valid,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_valid,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic             dmem_ready,
    input  logic [31:0]      dmem_rdata,
    output logic             halted,
    output logic [31:0]      halt_pc,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic        run_q, ifex_valid;
    logic [31:0] pc, ifex_instr, ifex_pc;
    logic [31:0] regs [NUM_REGS];
    exmw_t       mw, ex_entry;
    logic        stall, mem_wait, fwd_a, fwd_b, flush, retire;
    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm, rv1, rv2, alu_y, target, mw_wdata;
    logic        dec_illegal, use_rs1, use_rs2, use_rd, taken, redirect, ex_halt, misaligned;
    alu_op_e     alu_op;

    function automatic logic bad_idx(input logic [4:0] idx);
        return 32'(idx) >= NUM_REGS;
    endfunction

    assign opcode   = ifex_instr[6:0];
    assign rd       = ifex_instr[11:7];
    assign f3       = ifex_instr[14:12];
    assign rs1      = ifex_instr[19:15];
    assign rs2      = ifex_instr[24:20];
    assign f7       = ifex_instr[31:25];
    assign mw_wdata = mw.mem ? dmem_rdata : mw.result;
    assign retire   = mw.valid && !mem_wait;

    assign imem_valid = run_q && !halted;
    assign imem_addr  = pc;
    assign dmem_valid = run_q && mw.valid && mw.mem;
    assign dmem_we    = mw.store;
    assign dmem_addr  = mw.result;
    assign dmem_wdata = mw.sdata;

    always_comb begin
        imm         = '0;
        dec_illegal = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        use_rd      = 1'b0;
        alu_op      = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                {use_rs1, use_rs2, use_rd} = 3'b111;
                dec_illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
                alu_op = alu_control(f3, f7[5], 1'b1);
            end
            OPC_OP_IMM: begin
                {use_rs1, use_rd} = 2'b11;
                imm = {{20{ifex_instr[31]}}, ifex_instr[31:20]};
                dec_illegal = (f3 == 3'b001 && f7 != 7'h00) ||
                              (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
                alu_op = alu_control(f3, f7[5], 1'b0);
            end
            OPC_LOAD, OPC_JALR: begin
                {use_rs1, use_rd} = 2'b11;
                imm = {{20{ifex_instr[31]}}, ifex_instr[31:20]};
                dec_illegal = (opcode == OPC_LOAD) ? (f3 != 3'b010) : (f3 != 3'b000);
            end
            OPC_STORE: begin
                {use_rs1, use_rs2} = 2'b11;
                imm = {{20{ifex_instr[31]}}, ifex_instr[31:25], ifex_instr[11:7]};
                dec_illegal = (f3 != 3'b010);
            end
            OPC_BRANCH: begin
                {use_rs1, use_rs2} = 2'b11;
                imm = {{19{ifex_instr[31]}}, ifex_instr[31], ifex_instr[7],
                       ifex_instr[30:25], ifex_instr[11:8], 1'b0};
                dec_illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_JAL: begin
                use_rd = 1'b1;
                imm = {{11{ifex_instr[31]}}, ifex_instr[31], ifex_instr[19:12],
                       ifex_instr[20], ifex_instr[30:21], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                use_rd = 1'b1;
                imm = {ifex_instr[31:12], 12'b0};
            end
            OPC_SYSTEM: dec_illegal = 1'b1;
            default:    dec_illegal = 1'b1;
        endcase
        if ((use_rs1 && bad_idx(rs1)) || (use_rs2 && bad_idx(rs2)) || (use_rd && bad_idx(rd)))
            dec_illegal = 1'b1;
    end

    always_comb begin
        rv1 = fwd_a ? mw_wdata : (rs1 == 5'd0 || bad_idx(rs1)) ? '0 : regs[rs1[IDX_W-1:0]];
        rv2 = fwd_b ? mw_wdata : (rs2 == 5'd0 || bad_idx(rs2)) ? '0 : regs[rs2[IDX_W-1:0]];
        alu_y = alu(alu_op,
                    (opcode == OPC_AUIPC) ? ifex_pc : (opcode == OPC_LUI) ? '0 : rv1,
                    (opcode == OPC_OP) ? rv2 : imm);
        case (f3)
            F3_BEQ:  taken = (rv1 == rv2);
            F3_BNE:  taken = (rv1 != rv2);
            F3_BLT:  taken = ($signed(rv1) < $signed(rv2));
            F3_BGE:  taken = ($signed(rv1) >= $signed(rv2));
            F3_BLTU: taken = (rv1 < rv2);
            F3_BGEU: taken = (rv1 >= rv2);
            default: taken = 1'b0;
        endcase
        target     = (opcode == OPC_JALR) ? (alu_y & ~32'd1) : (ifex_pc + imm);
        misaligned = (opcode == OPC_LOAD || opcode == OPC_STORE) && (alu_y[1:0] != 2'b00);
        ex_halt    = ifex_valid && (dec_illegal || misaligned);
        redirect   = ifex_valid && !ex_halt && (opcode == OPC_JAL || opcode == OPC_JALR ||
                     (opcode == OPC_BRANCH && taken));
        ex_entry        = '0;
        ex_entry.valid  = ifex_valid && !ex_halt;
        ex_entry.mem    = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
        ex_entry.store  = (opcode == OPC_STORE);
        ex_entry.wb     = use_rd;
        ex_entry.rd     = rd;
        ex_entry.result = (opcode == OPC_JAL || opcode == OPC_JALR) ? (ifex_pc + 32'd4) : alu_y;
        ex_entry.sdata  = rv2;
    end

    riscv_hazard_unit #(.FORWARDING(FORWARDING)) u_hazard (
        .mw          (mw),
        .dmem_ready  (dmem_ready),
        .ex_valid    (ifex_valid),
        .rs1         (rs1),
        .rs2         (rs2),
        .ex_redirect (redirect),
        .ex_halt     (ex_halt),
        .mem_wait    (mem_wait),
        .stall       (stall),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .flush       (flush)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            run_q      <= 1'b0;
            ifex_valid <= 1'b0;
            mw         <= '0;
            halted     <= 1'b0;
            halt_pc    <= '0;
            instret    <= '0;
        end else begin
            run_q <= 1'b1;
            if (retire)
                instret <= instret + CNT_W'(1);
            // A memory wait holds MW; a RAW stall lets MW retire and leaves a bubble behind it.
            if (!mem_wait)
                mw <= stall ? '0 : ex_entry;
            if (!stall) begin
                if (ex_halt) begin
                    halted  <= 1'b1;
                    halt_pc <= ifex_pc;
                end
                if (flush) begin
                    ifex_valid <= 1'b0;
                    if (redirect)
                        pc <= target;
                end else if (imem_valid && imem_ready) begin
                    ifex_valid <= 1'b1;
                    ifex_instr <= imem_rdata;
                    ifex_pc    <= pc;
                    pc         <= pc + 32'd4;
                end else begin
                    ifex_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && retire && mw.wb && mw.rd != 5'd0)
            regs[mw.rd[IDX_W-1:0]] <= mw_wdata;
    end

endmodule
